// File: rtl/control4mo.sv
// control4mo: Memory Operation stage controller. Takes the MA->MO latch
// contents and runs loads/stores on a req/ack data-memory bus. While an access
// is in flight it stalls upstream. Afterwards it retires the instruction, with
// any load data, to write-back.
module control4mo #(
    parameter int           TIMEOUT  = 15,
    parameter logic [11:0]  ERR_DATA = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_in,
    input  logic [11:0] pc_in,
    input  logic [11:0] instr_in,
    input  logic [3:0]  instr_set_in,
    input  logic [1:0]  mem_op_in,
    input  logic [11:0] addr_in,
    input  logic [11:0] wdata_in,
    output logic        stall_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [11:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [11:0] mem_rdata,
    output logic        enable_out,
    output logic [11:0] pc_out,
    output logic [11:0] instr_out,
    output logic [3:0]  instr_set_out,
    output logic [11:0] rdata_out,
    output logic        err_out
);

    typedef enum logic {IDLE, BUSY} state_t;

    // Last BUSY cycle index before the access is abandoned.
    localparam logic [3:0] LAST_CNT = 4'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d;
    logic [11:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [11:0] pc_q, pc_d, instr_q, instr_d;
    logic [3:0]  iset_q, iset_d;
    logic        en_out_q, en_out_d, err_q, err_d;
    logic [11:0] pc_out_q, pc_out_d, instr_out_q, instr_out_d, rdata_q, rdata_d;
    logic [3:0]  iset_out_q, iset_out_d;
    logic        is_mem;

    // Only load (01) and store (10) touch memory; 11 is treated as none.
    assign is_mem = (mem_op_in == 2'b01) || (mem_op_in == 2'b10);

    // Next-state and datapath logic for the IDLE/BUSY controller.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        iset_d      = iset_q;
        en_out_d    = 1'b0;
        err_d       = 1'b0;
        pc_out_d    = pc_out_q;
        instr_out_d = instr_out_q;
        iset_out_d  = iset_out_q;
        rdata_d     = rdata_q;
        stall_out   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_in) begin
                    if (is_mem) begin
                        stall_out = 1'b1;
                        req_d     = 1'b1;
                        we_d      = (mem_op_in == 2'b10);
                        addr_d    = addr_in;
                        wdata_d   = wdata_in;
                        pc_d      = pc_in;
                        instr_d   = instr_in;
                        iset_d    = instr_set_in;
                        cnt_d     = 4'd0;
                        state_d   = BUSY;
                    end else begin
                        en_out_d    = 1'b1;
                        pc_out_d    = pc_in;
                        instr_out_d = instr_in;
                        iset_out_d  = instr_set_in;
                        rdata_d     = 12'h000;
                    end
                end
            end
            BUSY: begin
                stall_out = 1'b1;
                // An ack in the final timeout cycle takes priority over the timeout.
                if (mem_ack || cnt_q == LAST_CNT) begin
                    req_d       = 1'b0;
                    we_d        = 1'b0;
                    en_out_d    = 1'b1;
                    err_d       = !mem_ack;
                    pc_out_d    = pc_q;
                    instr_out_d = instr_q;
                    iset_out_d  = iset_q;
                    if (!mem_ack)  rdata_d = ERR_DATA;
                    else if (we_q) rdata_d = 12'h000;
                    else           rdata_d = mem_rdata;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; a synchronous reset clears everything, including an in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            pc_q        <= '0;
            instr_q     <= '0;
            iset_q      <= '0;
            en_out_q    <= 1'b0;
            err_q       <= 1'b0;
            pc_out_q    <= '0;
            instr_out_q <= '0;
            iset_out_q  <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            iset_q      <= iset_d;
            en_out_q    <= en_out_d;
            err_q       <= err_d;
            pc_out_q    <= pc_out_d;
            instr_out_q <= instr_out_d;
            iset_out_q  <= iset_out_d;
            rdata_q     <= rdata_d;
        end
    end

    assign mem_req       = req_q;
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign enable_out    = en_out_q;
    assign err_out       = err_q;
    assign pc_out        = pc_out_q;
    assign instr_out     = instr_out_q;
    assign instr_set_out = iset_out_q;
    assign rdata_out     = rdata_q;

endmodule

// File: tb/tb_control4mo.sv
// Directed bench for control4mo with TIMEOUT=4. Inputs change 1 time unit
// after each rising edge, and outputs are sampled at the same point.
module tb_control4mo;

    logic        clk = 1'b0;
    logic        rst, enable_in, mem_ack;
    logic [11:0] pc_in, instr_in, addr_in, wdata_in, mem_rdata;
    logic [3:0]  instr_set_in;
    logic [1:0]  mem_op_in;
    logic        stall_out, mem_req, mem_we, enable_out, err_out;
    logic [11:0] mem_addr, mem_wdata, pc_out, instr_out, rdata_out;
    logic [3:0]  instr_set_out;
    int total = 0;
    int bad   = 0;

    control4mo #(.TIMEOUT(4), .ERR_DATA(12'h000)) dut (
        .clk(clk), .rst(rst), .enable_in(enable_in), .pc_in(pc_in),
        .instr_in(instr_in), .instr_set_in(instr_set_in), .mem_op_in(mem_op_in),
        .addr_in(addr_in), .wdata_in(wdata_in), .stall_out(stall_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .enable_out(enable_out), .pc_out(pc_out), .instr_out(instr_out),
        .instr_set_out(instr_set_out), .rdata_out(rdata_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [11:0] pc, input logic [11:0] ins,
                         input logic [11:0] addr, input logic [11:0] wd);
        enable_in = 1'b1; mem_op_in = op; pc_in = pc; instr_in = ins;
        instr_set_in = 4'h5; addr_in = addr; wdata_in = wd;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable_in = 1'b0; mem_ack = 1'b0; mem_op_in = 2'b00;
        pc_in = '0; instr_in = '0; instr_set_in = '0; addr_in = '0; wdata_in = '0; mem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        total++;
        if ({stall_out, mem_req, mem_we, enable_out, err_out} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=00000", {stall_out, mem_req, mem_we, enable_out, err_out});
        end
        total++;
        if ({mem_addr, mem_wdata, pc_out, instr_out, instr_set_out, rdata_out} !== 64'h0) begin
            bad++; $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, pc_out, instr_out, instr_set_out, rdata_out});
        end
    endtask

    task automatic test_nonmem();
        issue(2'b00, 12'h010, 12'h3A5, 12'h0, 12'h0);
        #1;
        total++;
        if (stall_out !== 1'b0) begin bad++; $display("FAIL nonmem_stall got=%b exp=0", stall_out); end
        tick();
        enable_in = 1'b0;
        total++;
        if ({enable_out, err_out, stall_out, pc_out, instr_out, instr_set_out, rdata_out} !== {3'b100, 12'h010, 12'h3A5, 4'h5, 12'h000}) begin
            bad++; $display("FAIL nonmem_retire got en=%b err=%b st=%b pc=%h ins=%h set=%h rd=%h exp en=1 err=0 st=0 pc=010 ins=3a5 set=5 rd=000",
                            enable_out, err_out, stall_out, pc_out, instr_out, instr_set_out, rdata_out);
        end
        tick();
        total++;
        if (enable_out !== 1'b0 || pc_out !== 12'h010) begin
            bad++; $display("FAIL nonmem_hold got en=%b pc=%h exp en=0 pc=010", enable_out, pc_out);
        end
    endtask

    task automatic test_load();
        issue(2'b01, 12'h020, 12'h111, 12'h0F0, 12'h0);
        #1;
        total++;
        if (stall_out !== 1'b1) begin bad++; $display("FAIL load_accept_stall got=%b exp=1", stall_out); end
        for (int i = 0; i < 3; i++) begin
            tick();
            enable_in = 1'b1; addr_in = 12'hFFF; mem_op_in = 2'b00;  // ignored while busy
            #1;
            total++;
            if ({mem_req, mem_we, stall_out, enable_out, mem_addr} !== {4'b1010, 12'h0F0}) begin
                bad++; $display("FAIL load_busy%0d got req=%b we=%b st=%b en=%b addr=%h exp req=1 we=0 st=1 en=0 addr=0f0",
                                i, mem_req, mem_we, stall_out, enable_out, mem_addr);
            end
            enable_in = 1'b0;
            if (i == 2) begin mem_ack = 1'b1; mem_rdata = 12'hABC; end
        end
        tick();
        mem_ack = 1'b0;
        total++;
        if ({mem_req, stall_out, enable_out, err_out, rdata_out, pc_out} !== {4'b0010, 12'hABC, 12'h020}) begin
            bad++; $display("FAIL load_retire got req=%b st=%b en=%b err=%b rd=%h pc=%h exp req=0 st=0 en=1 err=0 rd=abc pc=020",
                            mem_req, stall_out, enable_out, err_out, rdata_out, pc_out);
        end
    endtask

    task automatic test_timeout();
        issue(2'b01, 12'h030, 12'h222, 12'h0AA, 12'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            enable_in = 1'b0;
            total++;
            if (mem_req !== 1'b1 || enable_out !== 1'b0) begin
                bad++; $display("FAIL timeout_req%0d got req=%b en=%b exp req=1 en=0", i, mem_req, enable_out);
            end
        end
        tick();
        total++;
        if ({mem_req, enable_out, err_out, rdata_out} !== {3'b011, 12'h000}) begin
            bad++; $display("FAIL timeout_retire got req=%b en=%b err=%b rd=%h exp req=0 en=1 err=1 rd=000",
                            mem_req, enable_out, err_out, rdata_out);
        end
        mem_ack = 1'b1; mem_rdata = 12'h777;
        tick();
        mem_ack = 1'b0;
        total++;
        if ({mem_req, enable_out, err_out, stall_out, rdata_out} !== {4'b0000, 12'h000}) begin
            bad++; $display("FAIL timeout_late_ack got req=%b en=%b err=%b st=%b rd=%h exp 0 0 0 0 000",
                            mem_req, enable_out, err_out, stall_out, rdata_out);
        end
    endtask

    task automatic test_ack_at_timeout();
        issue(2'b01, 12'h040, 12'h333, 12'h0BB, 12'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            enable_in = 1'b0;
            if (i == 3) begin mem_ack = 1'b1; mem_rdata = 12'h7E1; end
        end
        tick();
        mem_ack = 1'b0;
        total++;
        if ({enable_out, err_out, rdata_out} !== {2'b10, 12'h7E1}) begin
            bad++; $display("FAIL ack_at_timeout got en=%b err=%b rd=%h exp en=1 err=0 rd=7e1", enable_out, err_out, rdata_out);
        end
    endtask

    task automatic test_store();
        issue(2'b10, 12'h050, 12'h444, 12'h020, 12'h555);
        tick();
        enable_in = 1'b0;
        total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 12'h020, 12'h555}) begin
            bad++; $display("FAIL store_bus got req=%b we=%b addr=%h wd=%h exp req=1 we=1 addr=020 wd=555",
                            mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_ack = 1'b1; mem_rdata = 12'hDDD;
        tick();
        mem_ack = 1'b0;
        total++;
        if ({mem_req, mem_we, enable_out, err_out, rdata_out} !== {4'b0010, 12'h000}) begin
            bad++; $display("FAIL store_retire got req=%b we=%b en=%b err=%b rd=%h exp req=0 we=0 en=1 err=0 rd=000",
                            mem_req, mem_we, enable_out, err_out, rdata_out);
        end
    endtask

    task automatic test_back_to_back();
        issue(2'b00, 12'h060, 12'hA01, 12'h0, 12'h0);
        tick();
        issue(2'b11, 12'h061, 12'hA02, 12'h0, 12'h0);  // reserved op behaves as none
        total++;
        if (enable_out !== 1'b1 || pc_out !== 12'h060) begin
            bad++; $display("FAIL b2b_first got en=%b pc=%h exp en=1 pc=060", enable_out, pc_out);
        end
        tick();
        enable_in = 1'b0;
        total++;
        if ({enable_out, stall_out, mem_req, pc_out, instr_out} !== {3'b100, 12'h061, 12'hA02}) begin
            bad++; $display("FAIL b2b_second got en=%b st=%b req=%b pc=%h ins=%h exp en=1 st=0 req=0 pc=061 ins=a02",
                            enable_out, stall_out, mem_req, pc_out, instr_out);
        end
    endtask

    task automatic test_reset_mid();
        issue(2'b01, 12'h070, 12'h555, 12'h0CC, 12'h0);
        tick();
        enable_in = 1'b0;
        tick();
        total++;
        if (mem_req !== 1'b1) begin bad++; $display("FAIL rstmid_busy got req=%b exp=1", mem_req); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({mem_req, stall_out, enable_out, err_out, mem_addr, pc_out, instr_out, rdata_out} !== 52'h0) begin
            bad++; $display("FAIL rstmid_clear got req=%b st=%b en=%b err=%b addr=%h pc=%h ins=%h rd=%h exp all 0",
                            mem_req, stall_out, enable_out, err_out, mem_addr, pc_out, instr_out, rdata_out);
        end
        mem_ack = 1'b1; mem_rdata = 12'h999;
        issue(2'b00, 12'h7FF, 12'h111, 12'h0, 12'h0);
        tick();
        enable_in = 1'b0; mem_ack = 1'b0;
        total++;
        if ({enable_out, err_out, mem_req, pc_out, instr_out, rdata_out} !== {3'b100, 12'h7FF, 12'h111, 12'h000}) begin
            bad++; $display("FAIL rstmid_after got en=%b err=%b req=%b pc=%h ins=%h rd=%h exp en=1 err=0 req=0 pc=7ff ins=111 rd=000",
                            enable_out, err_out, mem_req, pc_out, instr_out, rdata_out);
        end
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_load();
        test_timeout();
        test_ack_at_timeout();
        test_store();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control4mo.md
Name: control4mo

Overview:
- Memory Operation (MO) stage controller; the consumer end of the MA->MO latch.
- Accepts the instruction, PC and memory address produced by the MA stage and performs the load/store on the data-memory bus with a req/ack handshake.
- Stalls upstream while the access is outstanding, then presents the retired instruction and any load data to the write-back side.
- Non-memory instructions pass through with 1-cycle latency.

Parameters:
TIMEOUT, 15, max cycles to wait for mem_ack after mem_req rises (1..15, 4-bit counter)
ERR_DATA, 12'h000, value driven on rdata_out when an access times out

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
enable_in  input  1  valid instruction from MA->MO latch this cycle
pc_in  input  12  PC of incoming instruction
instr_in  input  12  incoming instruction word
instr_set_in  input  4  incoming instruction-set selector
mem_op_in  input  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
addr_in  input  12  data address computed by MA
wdata_in  input  12  store data
stall_out  output  1  upstream must hold inputs and not advance
mem_req  output  1  data-memory request, held until ack or timeout
mem_we  output  1  1 = store, 0 = load; valid while mem_req=1
mem_addr  output  12  captured address; valid while mem_req=1
mem_wdata  output  12  captured store data; valid while mem_req=1
mem_ack  input  1  memory completes access; sampled only while mem_req=1
mem_rdata  input  12  load data; valid in the mem_ack cycle
enable_out  output  1  1-cycle pulse: instruction retired from MO
pc_out  output  12  PC of retired instruction
instr_out  output  12  retired instruction
instr_set_out  output  4  retired instruction set
rdata_out  output  12  load data (0 for non-loads, ERR_DATA on timeout)
err_out  output  1  qualifies enable_out: access timed out

Behaviour:
- Reset (rst=1 at edge): state IDLE, counter 0. stall_out, mem_req, mem_we, enable_out and err_out all 0. mem_addr, mem_wdata, pc_out, instr_out, instr_set_out and rdata_out all 0. Reset mid-access drops mem_req at that edge; a late mem_ack is ignored.
- States: IDLE, BUSY.
- IDLE, enable_in=1, op none/reserved:
  - Next edge: pc/instr/instr_set copied to outputs, rdata_out=0, err_out=0, enable_out=1.
  - Latency 1; stall_out stays 0.
- IDLE, enable_in=1, op load/store:
  - stall_out=1 combinationally in that cycle.
  - Next edge: capture all inputs, mem_req=1, mem_we=(op==store), counter=0, state BUSY.
- BUSY:
  - stall_out=1; enable_in and all inputs ignored.
  - Counter increments each cycle mem_ack=0.
- BUSY, mem_ack=1:
  - Next edge: mem_req=0, mem_we=0, enable_out=1, err_out=0.
  - rdata_out = mem_rdata for load, 0 for store; state IDLE.
  - Minimum load/store latency: 2 cycles from acceptance to enable_out (ack in first BUSY cycle).
- BUSY, counter==TIMEOUT-1, mem_ack=0:
  - Next edge: mem_req=0, enable_out=1, err_out=1, rdata_out=ERR_DATA, state IDLE.
  - mem_ack and timeout in the same cycle: ack wins, err_out=0.
- enable_out and err_out are single-cycle pulses, otherwise 0.
- pc_out, instr_out, instr_set_out and rdata_out hold their last value between pulses.
- Back-to-back: on the IDLE cycle after a retire, a new enable_in is accepted with no bubble for non-memory ops.
- mem_addr and mem_wdata are stable for the whole mem_req high period.

Test Plan:
- Reset then non-mem op: enable_in=1, op=00, pc=12'h010, instr=12'h3A5 -> next cycle enable_out=1, pc_out=12'h010, instr_out=12'h3A5, rdata_out=0, stall_out never 1.
- Load with ack on the 3rd BUSY cycle: addr=12'h0F0, mem_rdata=12'hABC -> mem_req=1 for 3 cycles, mem_we=0, mem_addr=12'h0F0; stall_out=1 from acceptance cycle until the retire edge; then enable_out=1, rdata_out=12'hABC, err_out=0.
- Store with immediate ack: wdata=12'h555, addr=12'h020 -> mem_we=1, mem_wdata=12'h555 for 1 cycle; enable_out 2 cycles after acceptance; rdata_out=0.
- Timeout with TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, then enable_out=1, err_out=1, rdata_out=12'h000; a mem_ack arriving 1 cycle later is ignored.
- Ack coincident with the last timeout cycle -> err_out=0, rdata_out=mem_rdata.
- rst asserted in 2nd BUSY cycle -> next edge mem_req=0, stall_out=0, all outputs 0, state IDLE; a following non-mem op retires normally after 1 cycle.
